load_ext_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 28 ++
 rtl/field_ext.sv | 25 ++
 rtl/load_ext_unit.sv | 143 ++++++++++++++
 tb/tb_load_ext_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Load opcodes and immediate extension encodings for the MIPS datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    typedef enum logic [1:0] {
        LD_WORD = 2'd0,
        LD_HALF = 2'd1,
        LD_BYTE = 2'd2
    } ld_size_e;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/field_ext.sv
// ============================================================================
// Module  : field_ext
// Brief   : Sign- or zero-extends a W-bit field to 32 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module field_ext #(
    parameter int W = 16
) (
    input  logic [W-1:0] field,
    input  logic         zero_sel,
    output logic [31:0]  ext
);

    logic w_fill;

    always_comb begin
        w_fill = zero_sel ? 1'b0 : field[W-1];
        ext    = {{(32-W){w_fill}}, field};
    end

endmodule : field_ext

`default_nettype wire

// File: rtl/load_ext_unit.sv
// ============================================================================
// Module  : load_ext_unit
// Brief   : Load lane select + extension and immediate extension, one-cycle
//           registered outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_ext_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] imm,
    input  logic [1:0]  ext_op,
    output logic        out_valid,
    output logic [31:0] load_data,
    output logic [31:0] imm_ext,
    output logic        align_err
);

    logic        out_valid_d, out_valid_q;
    logic [31:0] load_data_d, load_data_q;
    logic [31:0] imm_ext_d,   imm_ext_q;
    logic        align_err_d, align_err_q;

    ld_size_e    w_size;
    logic        w_zero;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_byte_ext;
    logic [31:0] w_half_ext;
    logic [31:0] w_imm_se_ze;
    logic        w_imm_zero;

    // Opcode decode; unrecognised opcodes behave as lbu.
    always_comb begin
        w_size     = LD_BYTE;
        w_zero     = 1'b1;
        w_misalign = 1'b0;
        case (op)
            OP_LW: begin
                w_size     = LD_WORD;
                w_zero     = 1'b1;
                w_misalign = (addr_lo != 2'b00);
            end
            OP_LH: begin
                w_size     = LD_HALF;
                w_zero     = 1'b0;
                w_misalign = addr_lo[0];
            end
            OP_LHU: begin
                w_size     = LD_HALF;
                w_zero     = 1'b1;
                w_misalign = addr_lo[0];
            end
            OP_LB: begin
                w_size = LD_BYTE;
                w_zero = 1'b0;
            end
            default: begin
                w_size = LD_BYTE;
                w_zero = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    field_ext #(.W(8)) u_byte_ext (
        .field    (w_byte),
        .zero_sel (w_zero),
        .ext      (w_byte_ext)
    );

    field_ext #(.W(16)) u_half_ext (
        .field    (w_half),
        .zero_sel (w_zero),
        .ext      (w_half_ext)
    );

    // Only EXT_SIGN sign-extends; the reserved encoding zero-extends.
    assign w_imm_zero = (ext_op != EXT_SIGN);

    field_ext #(.W(16)) u_imm_ext (
        .field    (imm),
        .zero_sel (w_imm_zero),
        .ext      (w_imm_se_ze)
    );

    always_comb begin
        out_valid_d = in_valid;
        load_data_d = load_data_q;
        imm_ext_d   = imm_ext_q;
        align_err_d = align_err_q;
        if (in_valid) begin
            case (w_size)
                LD_WORD: load_data_d = rdata;
                LD_HALF: load_data_d = w_half_ext;
                default: load_data_d = w_byte_ext;
            endcase
            imm_ext_d   = (ext_op == EXT_LUI) ? {imm, 16'h0000} : w_imm_se_ze;
            align_err_d = w_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            load_data_q <= RST_VAL;
            imm_ext_q   <= RST_VAL;
            align_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            load_data_q <= load_data_d;
            imm_ext_q   <= imm_ext_d;
            align_err_q <= align_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign load_data = load_data_q;
    assign imm_ext   = imm_ext_q;
    assign align_err = align_err_q;

endmodule : load_ext_unit

`default_nettype wire

// File: tb/tb_load_ext_unit.sv
// ============================================================================
// Module  : tb_load_ext_unit
// Brief   : Directed self-checking bench for load_ext_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_ext_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  op;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
    logic [15:0] imm;
    logic [1:0]  ext_op;
    logic        out_valid;
    logic [31:0] load_data;
    logic [31:0] imm_ext;
    logic        align_err;

    int errors = 0;
    int checks = 0;

    load_ext_unit #(.RST_VAL(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .addr_lo   (addr_lo),
        .rdata     (rdata),
        .imm       (imm),
        .ext_op    (ext_op),
        .out_valid (out_valid),
        .load_data (load_data),
        .imm_ext   (imm_ext),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [5:0] o, input logic [1:0] a,
                        input logic [31:0] d, input logic [15:0] i, input logic [1:0] e);
        in_valid = v;
        op       = o;
        addr_lo  = a;
        rdata    = d;
        imm      = i;
        ext_op   = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(1'b1, 6'd35, 2'd0, 32'hFFFF_FFFF, 16'hFFFF, 2'b00);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_load",  load_data, 32'h0000_0000);
        chk("rst_imm",   imm_ext,   32'h0000_0000);
        chk("rst_align", {31'd0, align_err}, 32'd0);
        rst = 1'b0;

        // Halfwords
        step(1'b1, 6'd33, 2'd0, 32'h8001_7FFE, 16'h0000, 2'b00);
        chk("lh0_valid", {31'd0, out_valid}, 32'd1);
        chk("lh0_data",  load_data, 32'h0000_7FFE);
        chk("lh0_align", {31'd0, align_err}, 32'd0);
        step(1'b1, 6'd33, 2'd2, 32'h8001_7FFE, 16'h0000, 2'b00);
        chk("lh2_data",  load_data, 32'hFFFF_8001);
        chk("lh2_align", {31'd0, align_err}, 32'd0);
        step(1'b1, 6'd37, 2'd2, 32'h8001_7FFE, 16'h0000, 2'b00);
        chk("lhu2_data", load_data, 32'h0000_8001);
        chk("lhu2_align", {31'd0, align_err}, 32'd0);

        // Bytes
        step(1'b1, 6'd32, 2'd0, 32'h80FF_7F01, 16'h0000, 2'b00);
        chk("lb0", load_data, 32'h0000_0001);
        step(1'b1, 6'd32, 2'd1, 32'h80FF_7F01, 16'h0000, 2'b00);
        chk("lb1", load_data, 32'h0000_007F);
        step(1'b1, 6'd32, 2'd2, 32'h80FF_7F01, 16'h0000, 2'b00);
        chk("lb2", load_data, 32'hFFFF_FFFF);
        step(1'b1, 6'd32, 2'd3, 32'h80FF_7F01, 16'h0000, 2'b00);
        chk("lb3", load_data, 32'hFFFF_FF80);
        step(1'b1, 6'd36, 2'd2, 32'h80FF_7F01, 16'h0000, 2'b00);
        chk("lbu2", load_data, 32'h0000_00FF);
        step(1'b1, 6'd0, 2'd3, 32'h80FF_7F01, 16'h0000, 2'b00);
        chk("unk3_data",  load_data, 32'h0000_0080);
        chk("unk3_align", {31'd0, align_err}, 32'd0);

        // Word and alignment
        step(1'b1, 6'd35, 2'd1, 32'hDEAD_BEEF, 16'h0000, 2'b00);
        chk("lw1_align", {31'd0, align_err}, 32'd1);
        chk("lw1_data",  load_data, 32'hDEAD_BEEF);
        step(1'b1, 6'd33, 2'd3, 32'h8001_7FFE, 16'h0000, 2'b00);
        chk("lh3_align", {31'd0, align_err}, 32'd1);
        chk("lh3_data",  load_data, 32'hFFFF_8001);
        step(1'b0, 6'd35, 2'd0, 32'h1234_5678, 16'h7777, 2'b01);
        chk("hold_err_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_err_align", {31'd0, align_err}, 32'd1);
        chk("hold_err_data",  load_data, 32'hFFFF_8001);
        step(1'b1, 6'd35, 2'd0, 32'hDEAD_BEEF, 16'h0000, 2'b00);
        chk("lw0_data",  load_data, 32'hDEAD_BEEF);
        chk("lw0_align", {31'd0, align_err}, 32'd0);
        chk("lw0_valid", {31'd0, out_valid}, 32'd1);

        // Immediate
        step(1'b1, 6'd35, 2'd0, 32'hDEAD_BEEF, 16'h8005, 2'b00);
        chk("imm_sign", imm_ext, 32'hFFFF_8005);
        step(1'b1, 6'd35, 2'd0, 32'hDEAD_BEEF, 16'h8005, 2'b01);
        chk("imm_zero", imm_ext, 32'h0000_8005);
        step(1'b1, 6'd35, 2'd0, 32'hDEAD_BEEF, 16'h8005, 2'b10);
        chk("imm_lui",  imm_ext, 32'h8005_0000);
        step(1'b1, 6'd35, 2'd0, 32'hDEAD_BEEF, 16'h8005, 2'b11);
        chk("imm_rsvd", imm_ext, 32'h0000_8005);
        step(1'b1, 6'd35, 2'd0, 32'hDEAD_BEEF, 16'h1234, 2'b00);
        chk("imm_pos",  imm_ext, 32'h0000_1234);

        // Hold
        step(1'b1, 6'd36, 2'd1, 32'h0000_A500, 16'h8005, 2'b00);
        chk("pre_hold_data", load_data, 32'h0000_00A5);
        chk("pre_hold_imm",  imm_ext,   32'hFFFF_8005);
        step(1'b0, 6'd32, 2'd3, 32'hFF00_0000, 16'h4321, 2'b10);
        chk("hold_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_data",  load_data, 32'h0000_00A5);
        chk("hold_imm",   imm_ext,   32'hFFFF_8005);
        chk("hold_align", {31'd0, align_err}, 32'd0);
        step(1'b1, 6'd32, 2'd3, 32'hFF00_0000, 16'h4321, 2'b10);
        chk("resume_valid", {31'd0, out_valid}, 32'd1);
        chk("resume_data",  load_data, 32'hFFFF_FFFF);
        chk("resume_imm",   imm_ext,   32'h4321_0000);

        // Reset in mid-stream clears registers again
        rst = 1'b1;
        step(1'b1, 6'd35, 2'd0, 32'hFFFF_FFFF, 16'hFFFF, 2'b00);
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_load",  load_data, 32'h0000_0000);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_load_ext_unit

`default_nettype wire
